video_timing_prog: RTL and testbench

- Runtime-programmable raster timing generator; successor to the fixed-parameter VGA timing block.
- Drives the pixel pipeline (pattern generator, encoder front-end) with pixel coordinates, sync pulses, data enable and frame/line start strobes.
- Adds clock-enable, programmable sync polarity, and validated shadow-register mode changes that take effect only at frame boundaries.
- All outputs are registered.

---
 rtl/video_timing_prog.sv | 203 ++++++++++++++++++++
 tb/tb_video_timing_prog.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_prog.sv
// Runtime-programmable raster timing generator.
// Two timing sets are held: the active set drives the raster and the pending
// set holds a validated request. The pending set is promoted to active only on
// the last pixel of a frame, so the raster never changes mid-frame.
module video_timing_prog #(
  parameter int   CW           = 12,
  parameter int   DEF_H_ACTIVE = 640,
  parameter int   DEF_H_FP     = 16,
  parameter int   DEF_H_SYNC   = 96,
  parameter int   DEF_H_BP     = 48,
  parameter int   DEF_V_ACTIVE = 480,
  parameter int   DEF_V_FP     = 10,
  parameter int   DEF_V_SYNC   = 2,
  parameter int   DEF_V_BP     = 33,
  parameter logic DEF_HPOL     = 1'b0,
  parameter logic DEF_VPOL     = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [CW-1:0] cfg_h_active,
  input  logic [CW-1:0] cfg_h_fp,
  input  logic [CW-1:0] cfg_h_sync,
  input  logic [CW-1:0] cfg_h_bp,
  input  logic [CW-1:0] cfg_v_active,
  input  logic [CW-1:0] cfg_v_fp,
  input  logic [CW-1:0] cfg_v_sync,
  input  logic [CW-1:0] cfg_v_bp,
  input  logic          cfg_hpol,
  input  logic          cfg_vpol,
  input  logic          cfg_load,
  output logic          cfg_pending,
  output logic          cfg_err,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  // Sums carry two extra bits so an over-range request cannot wrap to a legal value.
  localparam int SW = CW + 2;
  localparam logic [SW-1:0] MAX_TOTAL = SW'((1 << CW) - 1);

  typedef struct packed {
    logic [CW-1:0] h_active;
    logic [CW-1:0] h_fp;
    logic [CW-1:0] h_sync;
    logic [CW-1:0] h_bp;
    logic [CW-1:0] v_active;
    logic [CW-1:0] v_fp;
    logic [CW-1:0] v_sync;
    logic [CW-1:0] v_bp;
    logic          hpol;
    logic          vpol;
  } tset_t;

  localparam tset_t DEF_SET = '{
    h_active: CW'(DEF_H_ACTIVE), h_fp: CW'(DEF_H_FP),
    h_sync:   CW'(DEF_H_SYNC),   h_bp: CW'(DEF_H_BP),
    v_active: CW'(DEF_V_ACTIVE), v_fp: CW'(DEF_V_FP),
    v_sync:   CW'(DEF_V_SYNC),   v_bp: CW'(DEF_V_BP),
    hpol:     DEF_HPOL,          vpol: DEF_VPOL
  };

  tset_t         act_q, act_d, pset_q, pset_d, cfg_set;
  logic          cfg_pending_q, cfg_pending_d;
  logic          cfg_err_q, cfg_err_d;
  logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic          ls_q, ls_d, fs_q, fs_d;

  logic [SW-1:0] ht, vt, cfg_ht, cfg_vt;
  logic [SW-1:0] h_sync_start, h_sync_end, v_sync_start, v_sync_end;
  logic          h_last, v_last, boundary, cfg_ok, h_in_sync, v_in_sync;

  assign cfg_set = '{cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
                     cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp,
                     cfg_hpol, cfg_vpol};

  // Totals and sync windows of the running set, plus totals of the request.
  assign h_sync_start = SW'(act_q.h_active) + SW'(act_q.h_fp);
  assign h_sync_end   = h_sync_start + SW'(act_q.h_sync);
  assign ht           = h_sync_end + SW'(act_q.h_bp);
  assign v_sync_start = SW'(act_q.v_active) + SW'(act_q.v_fp);
  assign v_sync_end   = v_sync_start + SW'(act_q.v_sync);
  assign vt           = v_sync_end + SW'(act_q.v_bp);
  assign cfg_ht = SW'(cfg_h_active) + SW'(cfg_h_fp) + SW'(cfg_h_sync) + SW'(cfg_h_bp);
  assign cfg_vt = SW'(cfg_v_active) + SW'(cfg_v_fp) + SW'(cfg_v_sync) + SW'(cfg_v_bp);

  assign h_last   = (SW'(hc_q) == ht - SW'(1));
  assign v_last   = (SW'(vc_q) == vt - SW'(1));
  assign boundary = ce && h_last && v_last;

  // Porches may be zero; a zero active or sync width would make a degenerate raster.
  assign cfg_ok = (cfg_h_active != '0) && (cfg_h_sync != '0) &&
                  (cfg_v_active != '0) && (cfg_v_sync != '0) &&
                  (cfg_ht <= MAX_TOTAL) && (cfg_vt <= MAX_TOTAL);

  assign h_in_sync = (SW'(hc_q) >= h_sync_start) && (SW'(hc_q) < h_sync_end);
  assign v_in_sync = (SW'(vc_q) >= v_sync_start) && (SW'(vc_q) < v_sync_end);

  // Raster counters: hc wraps at the line end, vc advances on each hc wrap.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (ce) begin
      if (h_last) begin
        hc_d = '0;
        vc_d = v_last ? '0 : vc_q + CW'(1);
      end else begin
        hc_d = hc_q + CW'(1);
      end
    end
  end

  // Configuration path: promotion at the boundary first, so a coincident load lands in pending.
  always_comb begin
    act_d         = act_q;
    pset_d        = pset_q;
    cfg_pending_d = cfg_pending_q;
    cfg_err_d     = 1'b0;
    if (boundary && cfg_pending_q) begin
      act_d         = pset_q;
      cfg_pending_d = 1'b0;
    end
    if (cfg_load) begin
      if (cfg_ok) begin
        pset_d        = cfg_set;
        cfg_pending_d = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  // Output decode of the current counter position; everything holds while ce is low.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    de_d    = de_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    ls_d    = ls_q;
    fs_d    = fs_q;
    if (ce) begin
      x_d     = hc_q;
      y_d     = vc_q;
      de_d    = (hc_q < act_q.h_active) && (vc_q < act_q.v_active);
      hsync_d = h_in_sync ? act_q.hpol : ~act_q.hpol;
      vsync_d = v_in_sync ? act_q.vpol : ~act_q.vpol;
      ls_d    = (hc_q == '0);
      fs_d    = (hc_q == '0) && (vc_q == '0);
    end
  end

  // State and output registers; reset restores the default timing set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q         <= DEF_SET;
      pset_q        <= DEF_SET;
      cfg_pending_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      hc_q          <= '0;
      vc_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      de_q          <= 1'b0;
      hsync_q       <= ~DEF_HPOL;
      vsync_q       <= ~DEF_VPOL;
      ls_q          <= 1'b0;
      fs_q          <= 1'b0;
    end else begin
      act_q         <= act_d;
      pset_q        <= pset_d;
      cfg_pending_q <= cfg_pending_d;
      cfg_err_q     <= cfg_err_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      x_q           <= x_d;
      y_q           <= y_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      ls_q          <= ls_d;
      fs_q          <= fs_d;
    end
  end

  assign cfg_pending = cfg_pending_q;
  assign cfg_err     = cfg_err_q;
  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_prog.sv
// Scoreboard bench for video_timing_prog. A frame-position model predicts every
// registered output; a monitor on the falling edge pops and compares.
// Reduced default timings keep whole frames affordable in simulation.
module tb_video_timing_prog;

  localparam int CW = 12;
  localparam int D_HA = 16, D_HF = 2, D_HS = 3, D_HB = 3;   // HT = 24
  localparam int D_VA = 10, D_VF = 2, D_VS = 1, D_VB = 2;   // VT = 15
  localparam logic D_HP = 1'b0, D_VP = 1'b1;
  localparam int DEF_FRAME = 24 * 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic [CW-1:0] c_ha = '0, c_hf = '0, c_hs = '0, c_hb = '0;
  logic [CW-1:0] c_va = '0, c_vf = '0, c_vs = '0, c_vb = '0;
  logic c_hp = 1'b0, c_vp = 1'b0, cfg_load = 1'b0;
  logic cfg_pending, cfg_err, hsync, vsync, de, line_start, frame_start;
  logic [CW-1:0] x, y;

  video_timing_prog #(
    .CW(CW),
    .DEF_H_ACTIVE(D_HA), .DEF_H_FP(D_HF), .DEF_H_SYNC(D_HS), .DEF_H_BP(D_HB),
    .DEF_V_ACTIVE(D_VA), .DEF_V_FP(D_VF), .DEF_V_SYNC(D_VS), .DEF_V_BP(D_VB),
    .DEF_HPOL(D_HP), .DEF_VPOL(D_VP)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .cfg_h_active(c_ha), .cfg_h_fp(c_hf), .cfg_h_sync(c_hs), .cfg_h_bp(c_hb),
    .cfg_v_active(c_va), .cfg_v_fp(c_vf), .cfg_v_sync(c_vs), .cfg_v_bp(c_vb),
    .cfg_hpol(c_hp), .cfg_vpol(c_vp), .cfg_load(cfg_load),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err),
    .x(x), .y(y), .hsync(hsync), .vsync(vsync), .de(de),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic de, hs, vs, ls, fs, pend, err;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: timing sets as field arrays, raster as one frame position.
  int act[8], pnd[8];
  bit act_hp, act_vp, pnd_hp, pnd_vp, pend;
  int pos;
  obs_t cur;

  function automatic obs_t rst_obs();
    obs_t o;
    o = '0;
    o.hs = ~D_HP;
    o.vs = ~D_VP;
    return o;
  endfunction

  task automatic model_reset();
    act = '{D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB};
    pnd = act;
    act_hp = D_HP; act_vp = D_VP;
    pnd_hp = D_HP; pnd_vp = D_VP;
    pend = 1'b0;
    pos = 0;
    cur = rst_obs();
  endtask

  function automatic int frame_len();
    return (act[0] + act[1] + act[2] + act[3]) * (act[4] + act[5] + act[6] + act[7]);
  endfunction

  task automatic model_step(input bit ce_v, input bit ld);
    int cfg[8];
    int ht, vt, xi, yi;
    bit ok, bnd;
    cfg = '{int'(c_ha), int'(c_hf), int'(c_hs), int'(c_hb),
            int'(c_va), int'(c_vf), int'(c_vs), int'(c_vb)};
    ok = cfg[0] != 0 && cfg[2] != 0 && cfg[4] != 0 && cfg[6] != 0 &&
         (cfg[0] + cfg[1] + cfg[2] + cfg[3]) <= 4095 &&
         (cfg[4] + cfg[5] + cfg[6] + cfg[7]) <= 4095;
    cur.err = ld && !ok;
    bnd = 1'b0;
    if (ce_v) begin
      ht = act[0] + act[1] + act[2] + act[3];
      vt = act[4] + act[5] + act[6] + act[7];
      xi = pos % ht;
      yi = pos / ht;
      cur.x  = CW'(xi);
      cur.y  = CW'(yi);
      cur.de = (xi < act[0]) && (yi < act[4]);
      cur.hs = (xi >= act[0] + act[1] && xi < act[0] + act[1] + act[2]) ? act_hp : !act_hp;
      cur.vs = (yi >= act[4] + act[5] && yi < act[4] + act[5] + act[6]) ? act_vp : !act_vp;
      cur.ls = (xi == 0);
      cur.fs = (pos == 0);
      bnd = (pos == ht * vt - 1);
      pos = bnd ? 0 : pos + 1;
    end
    if (bnd && pend) begin
      act = pnd; act_hp = pnd_hp; act_vp = pnd_vp; pend = 1'b0;
    end
    if (ld && ok) begin
      pnd = cfg; pnd_hp = c_hp; pnd_vp = c_vp; pend = 1'b1;
    end
    cur.pend = pend;
    exp_q.push_back(cur);
    if (ld)
      $display("cfg_load t=%0t H=%0d/%0d/%0d/%0d V=%0d/%0d/%0d/%0d pol=%0d%0d accepted=%0d",
               $time, cfg[0], cfg[1], cfg[2], cfg[3], cfg[4], cfg[5], cfg[6], cfg[7],
               c_hp, c_vp, ok);
  endtask

  // One clock of stimulus: drive, predict, then advance past the next compare point.
  task automatic cyc(input bit ce_v, input bit ld);
    ce = ce_v;
    cfg_load = ld;
    model_step(ce_v, ld);
    @(negedge clk);
    #1;
    cfg_load = 1'b0;
  endtask

  task automatic set_cfg(input int ha, hf, hs, hb, va, vf, vs, vb, input bit hp, vp);
    c_ha = CW'(ha); c_hf = CW'(hf); c_hs = CW'(hs); c_hb = CW'(hb);
    c_va = CW'(va); c_vf = CW'(vf); c_vs = CW'(vs); c_vb = CW'(vb);
    c_hp = hp; c_vp = vp;
  endtask

  task automatic chk(input string name, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic rst_check(input string name);
    obs_t a;
    a = '{x, y, de, hsync, vsync, line_start, frame_start, cfg_pending, cfg_err};
    checks++;
    if (a !== rst_obs()) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, a, rst_obs(), $time);
    end
  endtask

  // Monitor: measure frame period and de count, and compare against the scoreboard.
  int cyc_n = 0, last_fs = 0, fs_period = 0, de_acc = 0, de_last = 0;
  bit fs_prev = 1'b0;
  always @(negedge clk) begin
    obs_t a, e;
    cyc_n++;
    a = '{x, y, de, hsync, vsync, line_start, frame_start, cfg_pending, cfg_err};
    if (frame_start && !fs_prev) begin
      fs_period = cyc_n - last_fs;
      last_fs   = cyc_n;
      de_last   = de_acc;
      de_acc    = 0;
    end
    fs_prev = frame_start;
    if (de) de_acc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t actual x=%0d y=%0d de/hs/vs/ls/fs/pend/err=%b expected x=%0d y=%0d de/hs/vs/ls/fs/pend/err=%b",
                 $time, a.x, a.y, {a.de, a.hs, a.vs, a.ls, a.fs, a.pend, a.err},
                 e.x, e.y, {e.de, e.hs, e.vs, e.ls, e.fs, e.pend, e.err});
      end
    end
  end

  initial begin
    int mode;
    model_reset();
    @(negedge clk);
    #1;
    rst_check("reset_state");
    rst = 1'b0;

    // Default timing, ce held high.
    for (int i = 0; i < 2 * DEF_FRAME + 40; i++) cyc(1'b1, 1'b0);
    chk("def_frame_period", fs_period, DEF_FRAME);
    chk("def_de_count", de_last, D_HA * D_VA);

    // ce toggling: outputs hold on idle cycles, the frame takes twice as long.
    for (int i = 0; i < 6 * DEF_FRAME + 40; i++) cyc(i % 2 == 0, 1'b0);
    chk("ce_half_frame_period", fs_period, 2 * DEF_FRAME);

    // Mid-frame reprogram to an 8x6 raster.
    for (int i = 0; i < 37; i++) cyc(1'b1, 1'b0);
    set_cfg(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("pending_after_load", int'(cfg_pending), 1);
    for (int i = 0; i < DEF_FRAME + 4 * 48; i++) cyc(1'b1, 1'b0);
    chk("small_frame_period", fs_period, 48);
    chk("small_de_count", de_last, 12);
    chk("pending_cleared", int'(cfg_pending), 0);

    // Rejected load: zero sync width.
    set_cfg(4, 1, 0, 1, 3, 1, 1, 1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    chk("reject_err_pulse", int'(cfg_err), 1);
    chk("reject_no_pending", int'(cfg_pending), 0);
    cyc(1'b1, 1'b0);
    chk("reject_err_one_clk", int'(cfg_err), 0);
    for (int i = 0; i < 150; i++) cyc(1'b1, 1'b0);
    chk("reject_period_kept", fs_period, 48);

    // Load coincident with the boundary while another set is pending.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
    set_cfg(5, 0, 1, 2, 2, 0, 1, 1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    for (int k = 0; k < 5000 && pos != frame_len() - 1; k++) cyc(1'b1, 1'b0);
    set_cfg(3, 2, 2, 3, 2, 1, 1, 1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    chk("coincident_pending_kept", int'(cfg_pending), 1);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
    chk("coincident_still_pending", int'(cfg_pending), 1);
    for (int i = 0; i < 200; i++) cyc(1'b1, 1'b0);
    chk("second_set_period", fs_period, 50);
    chk("second_set_applied", int'(cfg_pending), 0);

    // Randomized loads and clock-enable pattern.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        mode = $urandom_range(0, 9);
        set_cfg($urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(1, 3),
                $urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 2),
                $urandom_range(1, 2), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if (mode == 0) c_va = '0;
        if (mode == 1) c_hs = '0;
        if (mode == 2) begin c_ha = CW'(4090); c_hb = CW'(3); end
        if (mode == 3) begin c_vf = CW'(4093); end
        cyc($urandom_range(0, 3) != 0, 1'b1);
      end else begin
        cyc($urandom_range(0, 3) != 0, 1'b0);
      end
    end

    // Reset mid-frame with a set pending: defaults must come back.
    set_cfg(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    rst_check("reset_midframe_immediate");
    @(negedge clk);
    #1;
    rst_check("reset_held");
    model_reset();
    rst = 1'b0;
    cyc(1'b1, 1'b0);
    chk("post_reset_frame_start", int'(frame_start), 1);
    for (int i = 0; i < 2 * DEF_FRAME + 20; i++) cyc(1'b1, 1'b0);
    chk("post_reset_def_period", fs_period, DEF_FRAME);
    chk("post_reset_de_count", de_last, D_HA * D_VA);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
